pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the 8-bit microcontroller.
- Holds the PC and drives it into the PC incrementer. Takes the incremented value back as next-PC.
- Runs a single-outstanding request/ack handshake to instruction memory.
- Presents each fetched instruction, tagged with its PC, to decode through a one-entry valid/ready buffer.

---
 rtl/mcu_pkg.sv | 15 +
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 tb/tb_pc_fetch_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared MCU definitions: bus widths, reset PC and the fetch-sequencer state encoding.
// Pure declarations; no latency or flow control applies.
package mcu_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetcher; data reaches decode one cycle after ack.
// Decode stalls via instr_ready_i (one-entry buffer held); memory stalls by withholding imem_ack_i.
module pc_fetch_unit #(
   parameter int                ADDR_W   = mcu_pkg::ADDR_W,
   parameter int                DATA_W   = mcu_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = mcu_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              halt_i,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   output logic [ADDR_W-1:0] pc_o,
   input  logic [ADDR_W-1:0] pc_inc_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [DATA_W-1:0] imem_data_i,
   output logic              instr_valid_o,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] instr_pc_o,
   input  logic              instr_ready_i
);
   import mcu_pkg::*;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              squash_q, squash_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= '0;
         squash_q   <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         squash_q   <= squash_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   // addr_q is latched when a request starts, so a jump during an outstanding
   // request retargets pc_q without disturbing the address memory is serving.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      squash_d   = squash_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      unique case (state_q)
         IDLE: begin
            if (jump_i) begin
               pc_d = jump_addr_i;
            end else if (!halt_i) begin
               state_d = FETCH;
               addr_d  = pc_q;
            end
         end
         FETCH: begin
            if (imem_ack_i) begin
               squash_d = 1'b0;
               if (jump_i) begin
                  pc_d   = jump_addr_i;
                  addr_d = jump_addr_i;
               end else if (squash_q) begin
                  addr_d = pc_q;
               end else begin
                  instr_d    = imem_data_i;
                  instr_pc_d = pc_q;
                  pc_d       = pc_inc_i;
                  state_d    = HOLD;
               end
            end else if (jump_i) begin
               pc_d     = jump_addr_i;
               squash_d = 1'b1;
            end
         end
         HOLD: begin
            // A jump flushes the buffer even when decode is ready this cycle.
            if (jump_i) begin
               pc_d = jump_addr_i;
               if (!halt_i) begin
                  state_d = FETCH;
                  addr_d  = jump_addr_i;
               end else begin
                  state_d = IDLE;
               end
            end else if (instr_ready_i) begin
               if (!halt_i) begin
                  state_d = FETCH;
                  addr_d  = pc_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pc_o          = pc_q;
   assign imem_req_o    = (state_q == FETCH);
   assign imem_addr_o   = addr_q;
   assign instr_valid_o = (state_q == HOLD);
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized and directed bench for pc_fetch_unit with a program-order reference model.
`timescale 1ns/1ps
module tb_pc_fetch_unit;
   import mcu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        halt_i;
   logic        jump_i;
   logic [7:0]  jump_addr_i;
   logic [7:0]  pc_o;
   logic [7:0]  pc_inc_i;
   logic        imem_req_o;
   logic [7:0]  imem_addr_o;
   logic        imem_ack_i;
   logic [15:0] imem_data_i;
   logic        instr_valid_o;
   logic [15:0] instr_o;
   logic [7:0]  instr_pc_o;
   logic        instr_ready_i;

   pc_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .halt_i(halt_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
      .pc_o(pc_o), .pc_inc_i(pc_inc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .instr_valid_o(instr_valid_o),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i)
   );

   // external incrementer
   assign pc_inc_i = pc_o + 8'd1;

   initial clk = 1'b0;
   initial forever #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         deliv_cnt = 0;
   logic [7:0] last_pc = 8'h00;
   logic [7:0] exp_q[$];
   logic [7:0] req_log[$];
   int         fix_lat = 0;
   bit         rand_lat = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [7:0] a);
      return {a ^ 8'hA5, ~a};
   endfunction

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // Program order: after a jump the next delivered instruction is the target,
   // after each delivery the next one is its successor.
   task automatic model_jump(input logic [7:0] t);
      exp_q.delete();
      exp_q.push_back(t);
   endtask

   task automatic do_jump(input logic [7:0] t);
      jump_i      = 1'b1;
      jump_addr_i = t;
      model_jump(t);
      cyc();
      jump_i = 1'b0;
   endtask

   task automatic wait_deliv(input int target, input string name);
      int n = 0;
      while (deliv_cnt < target && n < 200) begin
         cyc();
         n++;
      end
      chk(name, 32'(deliv_cnt >= target), 32'd1);
   endtask

   task automatic run_one(input string name);
      int start = deliv_cnt;
      halt_i = 1'b0;
      cyc();
      halt_i = 1'b1;
      wait_deliv(start + 1, name);
      repeat (3) cyc();
   endtask

   // instruction memory: latency per request, measured from request start
   int mem_cnt = 0;
   int mem_lat = 0;
   bit lat_set = 1'b0;
   initial begin
      imem_ack_i  = 1'b0;
      imem_data_i = 16'h0;
      forever begin
         @(negedge clk);
         if (!rst_n || !imem_req_o) begin
            imem_ack_i = 1'b0;
            lat_set    = 1'b0;
         end else begin
            if (imem_ack_i) lat_set = 1'b0;
            if (!lat_set) begin
               mem_lat = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
               mem_cnt = 0;
               lat_set = 1'b1;
            end
            if (mem_cnt == mem_lat) begin
               imem_ack_i  = 1'b1;
               imem_data_i = mem_word(imem_addr_o);
            end else begin
               imem_ack_i  = 1'b0;
               imem_data_i = 16'($urandom);
               mem_cnt++;
            end
         end
      end
   end

   // monitor: protocol stability plus scoreboard pop on each accepted instruction
   bit          p_ok = 1'b0, p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_jump = 1'b0;
   logic [7:0]  p_addr = 8'h0, p_ipc = 8'h0, mon_e;
   logic [15:0] p_instr = 16'h0;
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            p_ok = 1'b0;
         end else begin
            if (p_ok && p_req && !p_ack) begin
               chk("req_stable", 32'(imem_req_o), 32'd1);
               chk("addr_stable", 32'(imem_addr_o), 32'(p_addr));
            end
            if (p_ok && p_valid) begin
               if (p_ready || p_jump) begin
                  chk("valid_drop", 32'(instr_valid_o), 32'd0);
               end else begin
                  chk("valid_hold", 32'(instr_valid_o), 32'd1);
                  chk("instr_hold", 32'(instr_o), 32'(p_instr));
                  chk("instr_pc_hold", 32'(instr_pc_o), 32'(p_ipc));
               end
            end
            if (imem_req_o && (!p_ok || !p_req || p_ack)) req_log.push_back(imem_addr_o);
            if (instr_valid_o && instr_ready_i && !jump_i) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL deliver: instruction at pc 0x%0h delivered, none expected", instr_pc_o);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("deliv_pc", 32'(instr_pc_o), 32'(mon_e));
                  chk("deliv_data", 32'(instr_o), 32'(mem_word(mon_e)));
                  exp_q.push_back(mon_e + 8'd1);
               end
               deliv_cnt++;
               last_pc = instr_pc_o;
            end
            p_ok    = 1'b1;
            p_req   = imem_req_o;
            p_ack   = imem_ack_i;
            p_addr  = imem_addr_o;
            p_valid = instr_valid_o;
            p_ready = instr_ready_i;
            p_jump  = jump_i;
            p_instr = instr_o;
            p_ipc   = instr_pc_o;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         d, s, cnt, n;
      logic [7:0] p;
      rst_n         = 1'b0;
      halt_i        = 1'b0;
      jump_i        = 1'b0;
      jump_addr_i   = 8'h00;
      instr_ready_i = 1'b1;
      model_jump(RESET_PC);
      repeat (3) cyc();
      chk("rst_pc", 32'(pc_o), 32'(RESET_PC));
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_addr", 32'(imem_addr_o), 32'd0);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_instr", 32'(instr_o), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc_o), 32'd0);
      rst_n = 1'b1;

      // back-to-back zero-wait fetches from reset
      wait_deliv(3, "t1_three");
      chk("t1_pc_after_third", 32'(pc_o), 32'h03);
      halt_i = 1'b1;
      wait_deliv(4, "t1_four");
      repeat (4) cyc();
      chk("t1_halt_no_req", 32'(imem_req_o), 32'd0);
      chk("t1_pc_idle", 32'(pc_o), 32'h04);
      chk("t1_deliv_cnt", 32'(deliv_cnt), 32'd4);

      // wrap from 0xFF
      do_jump(8'hFF);
      chk("t2_idle_jump_pc", 32'(pc_o), 32'hFF);
      run_one("t2_ff");
      chk("t2_last_pc", 32'(last_pc), 32'hFF);
      chk("t2_pc_wrap", 32'(pc_o), 32'h00);
      run_one("t2_00");
      chk("t2_wrap_addr", 32'(req_log[$]), 32'h00);

      // slow memory with halt raised mid-request
      fix_lat = 3;
      d = deliv_cnt;
      p = pc_o;
      halt_i = 1'b0;
      cyc();
      halt_i = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (imem_req_o) cnt++;
         cyc();
      end
      chk("t3_req_cycles", 32'(cnt), 32'd4);
      chk("t3_one_deliv", 32'(deliv_cnt - d), 32'd1);
      chk("t3_pc_inc", 32'(pc_o), 32'(8'(p + 8'd1)));
      fix_lat = 0;
      run_one("t6_resume");
      chk("t6_resume_addr", 32'(req_log[$]), 32'(8'(p + 8'd1)));

      // jump while a fetch is outstanding
      do_jump(8'h05);
      fix_lat = 3;
      s = req_log.size();
      d = deliv_cnt;
      halt_i = 1'b0;
      cyc();
      halt_i = 1'b1;
      do_jump(8'h40);
      wait_deliv(d + 1, "t4_deliv");
      repeat (3) cyc();
      chk("t4_req_count", 32'(req_log.size() - s), 32'd2);
      if (req_log.size() >= s + 2) begin
         chk("t4_first_req", 32'(req_log[s]), 32'h05);
         chk("t4_second_req", 32'(req_log[s+1]), 32'h40);
      end
      chk("t4_last_pc", 32'(last_pc), 32'h40);

      // jump in HOLD with decode ready
      fix_lat = 0;
      instr_ready_i = 1'b0;
      do_jump(8'h10);
      d = deliv_cnt;
      halt_i = 1'b0;
      n = 0;
      while (!instr_valid_o && n < 20) begin
         cyc();
         n++;
      end
      chk("t5a_hold", 32'(instr_valid_o), 32'd1);
      instr_ready_i = 1'b1;
      do_jump(8'h80);
      chk("t5a_flush", 32'(instr_valid_o), 32'd0);
      chk("t5a_req_addr", 32'(imem_addr_o), 32'h80);
      halt_i = 1'b1;
      wait_deliv(d + 1, "t5a_deliv");
      repeat (3) cyc();
      chk("t5a_deliv_cnt", 32'(deliv_cnt - d), 32'd1);
      chk("t5a_last_pc", 32'(last_pc), 32'h80);

      // jump coincident with ack
      fix_lat = 2;
      s = req_log.size();
      d = deliv_cnt;
      halt_i = 1'b0;
      cyc();
      halt_i = 1'b1;
      n = 0;
      while (!imem_ack_i && n < 10) begin
         cyc();
         n++;
      end
      chk("t5b_ack_seen", 32'(imem_ack_i), 32'd1);
      do_jump(8'h80);
      wait_deliv(d + 1, "t5b_deliv");
      repeat (3) cyc();
      chk("t5b_deliv_cnt", 32'(deliv_cnt - d), 32'd1);
      chk("t5b_req_count", 32'(req_log.size() - s), 32'd2);
      if (req_log.size() >= s + 2) begin
         chk("t5b_first_req", 32'(req_log[s]), 32'h81);
         chk("t5b_second_req", 32'(req_log[s+1]), 32'h80);
      end
      chk("t5b_last_pc", 32'(last_pc), 32'h80);

      // asynchronous reset in the middle of a request
      fix_lat = 3;
      halt_i = 1'b0;
      cyc();
      halt_i = 1'b1;
      cyc();
      chk("t6_req_pending", 32'(imem_req_o), 32'd1);
      model_jump(RESET_PC);
      rst_n = 1'b0;
      #1;
      chk("t6_arst_req", 32'(imem_req_o), 32'd0);
      chk("t6_arst_pc", 32'(pc_o), 32'(RESET_PC));
      chk("t6_arst_addr", 32'(imem_addr_o), 32'd0);
      chk("t6_arst_valid", 32'(instr_valid_o), 32'd0);
      chk("t6_arst_instr", 32'(instr_o), 32'd0);
      chk("t6_arst_instr_pc", 32'(instr_pc_o), 32'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("t6_post_rst_idle", 32'(imem_req_o), 32'd0);
      chk("t6_post_rst_pc", 32'(pc_o), 32'(RESET_PC));

      // random traffic against the program-order model
      rand_lat = 1'b1;
      d = deliv_cnt;
      for (int i = 0; i < 3000; i++) begin
         halt_i        = ($urandom_range(0, 7) == 0);
         instr_ready_i = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 15) == 0) begin
            jump_i      = 1'b1;
            jump_addr_i = 8'($urandom);
            model_jump(jump_addr_i);
         end else begin
            jump_i = 1'b0;
         end
         cyc();
      end
      jump_i        = 1'b0;
      halt_i        = 1'b1;
      instr_ready_i = 1'b1;
      repeat (20) cyc();
      chk("rand_progress", 32'((deliv_cnt - d) > 100), 32'd1);
      chk("rand_drained_req", 32'(imem_req_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
